// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             if_valid_inst_out;
    logic [31:0]      if_PC_out;
    logic [31:0]      if_NPC_out;
    logic [31:0]      if_IR_out;
    logic             ex_take_branch_out;
    logic             id_ready;
    logic             q_full;
    logic [CNT_W-1:0] q_count;
    logic [31:0]      if_id_PC;
    logic [31:0]      if_id_NPC;
    logic [31:0]      if_id_IR;
    logic             if_id_valid_inst;

    modport master (
        output if_valid_inst_out, if_PC_out, if_NPC_out, if_IR_out,
        output ex_take_branch_out, id_ready,
        input  q_full, q_count, if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst
    );

    modport slave (
        input  if_valid_inst_out, if_PC_out, if_NPC_out, if_IR_out,
        input  ex_take_branch_out, id_ready,
        output q_full, q_count, if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst
    );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID instruction FIFO with branch flush and full stall indication
module if_id_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOOP  = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    if_id_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic   full;
    logic   empty;
    logic   deq;
    logic   enq;
    logic   wr_en;
    entry_t head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign deq   = bus.id_ready && !empty;
    // A full queue still accepts when the head is leaving this cycle.
    assign enq   = bus.if_valid_inst_out && (!full || deq);
    assign wr_en = enq && !bus.ex_take_branch_out;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.ex_take_branch_out) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{pc: bus.if_PC_out, npc: bus.if_NPC_out, ir: bus.if_IR_out};
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        bus.if_id_valid_inst = 1'b0;
        bus.if_id_PC         = '0;
        bus.if_id_NPC        = '0;
        bus.if_id_IR         = NOOP;
        if (!empty) begin
            bus.if_id_valid_inst = 1'b1;
            bus.if_id_PC         = head.pc;
            bus.if_id_NPC        = head.npc;
            bus.if_id_IR         = head.ir;
        end
    end

    assign bus.q_full  = full;
    assign bus.q_count = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue with vector table and queue model
module tb_if_id_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOOP  = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOOP(NOOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ent_t;
    ent_t model[$];

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          br;
        bit          rdy;
        int          exp_count;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int sz;
        sz = model.size();
        chk({tag, " count"}, 32'(bus.q_count), 32'(sz));
        chk({tag, " full"},  32'(bus.q_full), 32'(sz == DEPTH));
        chk({tag, " valid"}, 32'(bus.if_id_valid_inst), 32'(sz > 0));
        chk({tag, " pc"},    bus.if_id_PC,  (sz > 0) ? model[0].pc  : 32'h0);
        chk({tag, " npc"},   bus.if_id_NPC, (sz > 0) ? model[0].npc : 32'h0);
        chk({tag, " ir"},    bus.if_id_IR,  (sz > 0) ? model[0].ir  : NOOP);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit br, input bit rdy);
        bus.if_valid_inst_out  = v;
        bus.if_PC_out          = pc;
        bus.if_NPC_out         = pc + 32'd4;
        bus.if_IR_out          = ir_of(pc);
        bus.ex_take_branch_out = br;
        bus.id_ready           = rdy;
    endtask

    // Applies one cycle of inputs, advances the model by the queue rules, then checks after the edge.
    task automatic step(input bit v, input logic [31:0] pc, input bit br, input bit rdy, input string tag);
        bit d, f, e;
        drive(v, pc, br, rdy);
        d = rdy && (model.size() > 0);
        f = (model.size() == DEPTH);
        e = v && (!f || d);
        if (br) begin
            model.delete();
        end else begin
            if (d) void'(model.pop_front());
            if (e) model.push_back('{pc, pc + 32'd4, ir_of(pc)});
        end
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset count", 32'(bus.q_count), 32'd0);
        chk("reset full",  32'(bus.q_full), 32'd0);
        chk("reset ir",    bus.if_id_IR, NOOP);
        chk("reset valid", 32'(bus.if_id_valid_inst), 32'd0);
        chk("reset pc",    bus.if_id_PC, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, "idle");

        // fill and drain, overflow refusal, flush, redirect target
        vecs.push_back('{1, 32'd0,   0, 0, 1, 1, 32'd0});
        vecs.push_back('{1, 32'd4,   0, 0, 2, 1, 32'd0});
        vecs.push_back('{1, 32'd8,   0, 0, 3, 1, 32'd0});
        vecs.push_back('{1, 32'd12,  0, 0, 4, 1, 32'd0});
        vecs.push_back('{1, 32'd16,  0, 0, 4, 1, 32'd0});
        vecs.push_back('{0, 32'd0,   0, 1, 3, 1, 32'd4});
        vecs.push_back('{0, 32'd0,   0, 1, 2, 1, 32'd8});
        vecs.push_back('{0, 32'd0,   0, 1, 1, 1, 32'd12});
        vecs.push_back('{0, 32'd0,   0, 1, 0, 0, 32'd0});
        vecs.push_back('{1, 32'd0,   0, 0, 1, 1, 32'd0});
        vecs.push_back('{1, 32'd4,   0, 0, 2, 1, 32'd0});
        vecs.push_back('{1, 32'd8,   0, 0, 3, 1, 32'd0});
        vecs.push_back('{1, 32'd12,  1, 0, 0, 0, 32'd0});
        vecs.push_back('{1, 32'h100, 0, 0, 1, 1, 32'h100});
        vecs.push_back('{0, 32'd0,   0, 1, 0, 0, 32'd0});
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].pc, vecs[i].br, vecs[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d count", i), 32'(bus.q_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d full", i),  32'(bus.q_full), 32'(vecs[i].exp_count == DEPTH));
            chk($sformatf("vec%0d valid", i), 32'(bus.if_id_valid_inst), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d pc", i),    bus.if_id_PC, vecs[i].exp_pc);
            chk($sformatf("vec%0d ir", i),    bus.if_id_IR, vecs[i].exp_valid ? ir_of(vecs[i].exp_pc) : NOOP);
        end

        // full queue with simultaneous push and pop, three pointer rotations
        for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0, "refill");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'(16 + 4 * i), 1'b0, 1'b1, "pushpop");
            chk($sformatf("pushpop%0d head", i), bus.if_id_PC, 32'(4 * (i + 1)));
            chk($sformatf("pushpop%0d count", i), 32'(bus.q_count), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, "drain");
        end
        chk("drain empty", 32'(bus.if_id_valid_inst), 32'd0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h200 + 4 * i), 1'b0, 1'b0, "prerst");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async rst count", 32'(bus.q_count), 32'd0);
        chk("async rst valid", 32'(bus.if_id_valid_inst), 32'd0);
        chk("async rst ir",    bus.if_id_IR, NOOP);
        model.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 32'h300, 1'b0, 1'b0, "post rst");
        chk("post rst head", bus.if_id_PC, 32'h300);
        step(1'b0, 32'h0, 1'b0, 1'b1, "post rst pop");

        // empty pop with offer: no fall-through, no dequeue
        drive(1'b1, 32'd20, 1'b0, 1'b1);
        #1;
        chk("nofall valid", 32'(bus.if_id_valid_inst), 32'd0);
        chk("nofall ir",    bus.if_id_IR, NOOP);
        step(1'b1, 32'd20, 1'b0, 1'b1, "empty pop");
        chk("empty pop count", 32'(bus.q_count), 32'd1);
        chk("empty pop head",  bus.if_id_PC, 32'd20);
        step(1'b0, 32'h0, 1'b0, 1'b1, "empty pop drain");

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit v, rdy, br;
            int phase;
            phase = i / 300;
            v   = ($urandom_range(0, 3) < ((phase % 2 == 0) ? 3 : 1));
            rdy = ($urandom_range(0, 3) < ((phase % 2 == 0) ? 1 : 3));
            br  = ($urandom_range(0, 39) == 0);
            step(v, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, br, rdy, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
